// File: rtl/control_unit.sv
// Moore sequencer for the cumulative-sum program (sum of i, i = 0..10) on the
// dedicated-processor datapath: R1 = i, R2 = sum, R3 = constant 1.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       iLe10,
    input  logic       aBTb,
    output logic       RFSrcMuxSel,
    output logic [2:0] readAddr1,
    output logic [2:0] readAddr2,
    output logic [2:0] writeAddr,
    output logic       writeEn,
    output logic       outBuf,
    output logic [2:0] aluOP,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_INIT_I   = 4'd1;
    localparam logic [3:0] S_INIT_S   = 4'd2;
    localparam logic [3:0] S_INIT_ONE = 4'd3;
    localparam logic [3:0] S_COMP     = 4'd4;
    localparam logic [3:0] S_ADD_SUM  = 4'd5;
    localparam logic [3:0] S_INC_I    = 4'd6;
    localparam logic [3:0] S_OUT      = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    localparam logic [2:0] ALU_ADD = 3'b000;

    localparam logic [2:0] R_ZERO = 3'd0;
    localparam logic [2:0] R_I    = 3'd1;
    localparam logic [2:0] R_SUM  = 3'd2;
    localparam logic [2:0] R_ONE  = 3'd3;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // The comparator's a <= b flag is not needed by this program.
    logic unused_abtb;
    assign unused_abtb = aBTb;

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:     state_d = start ? S_INIT_I : S_IDLE;
            S_INIT_I:   state_d = S_INIT_S;
            S_INIT_S:   state_d = S_INIT_ONE;
            S_INIT_ONE: state_d = S_COMP;
            S_COMP:     state_d = iLe10 ? S_ADD_SUM : S_DONE;
            S_ADD_SUM:  state_d = S_INC_I;
            S_INC_I:    state_d = S_OUT;
            S_OUT:      state_d = S_COMP;
            // Holding in DONE until start drops keeps a held start from relaunching.
            S_DONE:     state_d = start ? S_DONE : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        RFSrcMuxSel = 1'b0;
        readAddr1   = R_ZERO;
        readAddr2   = R_ZERO;
        writeAddr   = R_ZERO;
        writeEn     = 1'b0;
        outBuf      = 1'b0;
        aluOP       = ALU_ADD;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_INIT_I: begin
                writeAddr = R_I;
                writeEn   = 1'b1;
                busy      = 1'b1;
            end
            S_INIT_S: begin
                writeAddr = R_SUM;
                writeEn   = 1'b1;
                busy      = 1'b1;
            end
            S_INIT_ONE: begin
                RFSrcMuxSel = 1'b1;
                writeAddr   = R_ONE;
                writeEn     = 1'b1;
                busy        = 1'b1;
            end
            S_COMP: begin
                readAddr1 = R_I;
                busy      = 1'b1;
            end
            S_ADD_SUM: begin
                readAddr1 = R_SUM;
                readAddr2 = R_I;
                writeAddr = R_SUM;
                writeEn   = 1'b1;
                busy      = 1'b1;
            end
            S_INC_I: begin
                readAddr1 = R_I;
                readAddr2 = R_ONE;
                writeAddr = R_I;
                writeEn   = 1'b1;
                busy      = 1'b1;
            end
            S_OUT: begin
                readAddr1 = R_SUM;
                outBuf    = 1'b1;
                busy      = 1'b1;
            end
            S_DONE: begin
                readAddr1 = R_SUM;
                done      = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a behavioural datapath around the FSM, with the
// expected schedule and sums derived from the program's cycle timing.
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic       start;
    logic       iLe10;
    logic       aBTb;
    logic       RFSrcMuxSel;
    logic [2:0] readAddr1;
    logic [2:0] readAddr2;
    logic [2:0] writeAddr;
    logic       writeEn;
    logic       outBuf;
    logic [2:0] aluOP;
    logic       busy;
    logic       done;

    control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .iLe10       (iLe10),
        .aBTb        (aBTb),
        .RFSrcMuxSel (RFSrcMuxSel),
        .readAddr1   (readAddr1),
        .readAddr2   (readAddr2),
        .writeAddr   (writeAddr),
        .writeEn     (writeEn),
        .outBuf      (outBuf),
        .aluOP       (aluOP),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural datapath: 8-entry RF, ALU, output register.
    logic [7:0] rf [0:7];
    logic [7:0] out_port;
    int         cyc_cnt = 0;
    logic [7:0] trace_v [$];
    int         trace_c [$];

    logic       c_mux, c_we, c_ob;
    logic [2:0] c_ra1, c_ra2, c_wa, c_alu;
    logic [7:0] rd1_live, rd2_live, rd1_c, rd2_c;

    assign rd1_live = (readAddr1 == 3'd0) ? 8'd0 : rf[readAddr1];
    assign rd2_live = (readAddr2 == 3'd0) ? 8'd0 : rf[readAddr2];
    assign iLe10    = (rd1_live <= 8'd10);
    assign aBTb     = (rd1_live <= rd2_live);
    assign rd1_c    = (c_ra1 == 3'd0) ? 8'd0 : rf[c_ra1];
    assign rd2_c    = (c_ra2 == 3'd0) ? 8'd0 : rf[c_ra2];

    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return ~a;
            default: return 8'd0;
        endcase
    endfunction

    // Controls are captured mid-cycle so the datapath edge never races the FSM edge.
    always @(negedge clk) begin
        c_mux <= RFSrcMuxSel;
        c_we  <= writeEn;
        c_ob  <= outBuf;
        c_ra1 <= readAddr1;
        c_ra2 <= readAddr2;
        c_wa  <= writeAddr;
        c_alu <= aluOP;
    end

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (c_we && c_wa != 3'd0)
            rf[c_wa] <= c_mux ? 8'd1 : alu(c_alu, rd1_c, rd2_c);
        if (c_ob) begin
            out_port <= rd1_c;
            trace_v.push_back(rd1_c);
            trace_c.push_back(cyc_cnt);
        end
    end

    logic [16:0] outs;
    assign outs = {RFSrcMuxSel, readAddr1, readAddr2, writeAddr, writeEn, outBuf, aluOP, busy, done};

    function automatic logic [16:0] pk(input logic mux, input logic [2:0] ra1, input logic [2:0] ra2,
                                       input logic [2:0] wa, input logic we, input logic ob,
                                       input logic bsy, input logic dn);
        return {mux, ra1, ra2, wa, we, ob, 3'b000, bsy, dn};
    endfunction

    // Expected outputs for cycle c after the start edge (c = 0 means idle).
    function automatic logic [16:0] exp_fields(input int c);
        int ph;
        if (c == 1) return pk(1'b0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        if (c == 2) return pk(1'b0, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        if (c == 3) return pk(1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        if (c >= 4 && c <= 48) begin
            ph = (c - 4) % 4;
            case (ph)
                0:       return pk(1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
                1:       return pk(1'b0, 3'd2, 3'd1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
                2:       return pk(1'b0, 3'd1, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
                default: return pk(1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            endcase
        end
        if (c == 49) return pk(1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        return 17'd0;
    endfunction

    // mode 0: one-cycle start pulse, 1: start held through the run, 2: start toggled randomly while busy
    task automatic run(input int mode);
        logic [7:0] exp_sum;
        @(negedge clk);
        start = 1'b1;
        trace_v.delete();
        trace_c.delete();
        for (int c = 1; c <= 49; c++) begin
            @(negedge clk);
            if (mode == 0 && c == 1) start = 1'b0;
            if (mode == 2 && c <= 48) start = 1'($urandom_range(0, 1));
            chk($sformatf("m%0d_cyc%0d_decode", mode, c), 32'(outs), 32'(exp_fields(c)));
        end
        chk($sformatf("m%0d_outport_final", mode), 32'(out_port), 32'd55);
        chk($sformatf("m%0d_trace_len", mode), 32'(trace_v.size()), 32'd11);
        exp_sum = 8'd0;
        for (int k = 0; k < trace_v.size() && k < 11; k++) begin
            exp_sum = exp_sum + 8'(k);
            chk($sformatf("m%0d_trace%0d", mode, k), 32'(trace_v[k]), 32'(exp_sum));
            if (k > 0)
                chk($sformatf("m%0d_spacing%0d", mode, k), 32'(trace_c[k] - trace_c[k-1]), 32'd4);
        end
        if (mode == 1) begin
            for (int h = 0; h < 3; h++) begin
                @(negedge clk);
                chk($sformatf("held_done%0d", h), 32'(outs), 32'(exp_fields(49)));
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk($sformatf("m%0d_back_idle", mode), 32'(outs), 32'd0);
        @(negedge clk);
        chk($sformatf("m%0d_stay_idle", mode), 32'(outs), 32'd0);
        chk($sformatf("m%0d_outport_hold", mode), 32'(out_port), 32'd55);
    endtask

    initial begin
        for (int r = 0; r < 8; r++) rf[r] = 8'($urandom);
        out_port = 8'd0;
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset_outs%0d", i), 32'(outs), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("idle_no_start", 32'(outs), 32'd0);

        run(0);
        run(1);
        run(0);
        run(2);
        run(2);

        // Async reset in ADD_SUM of loop pass 5 (cycle 25).
        for (int r = 1; r < 4; r++) rf[r] = 8'($urandom);
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        chk("pre_reset_add_sum", 32'(outs), 32'(exp_fields(25)));
        reset = 1'b0;
        #1;
        chk("midrun_reset_we", 32'(writeEn), 32'd0);
        chk("midrun_reset_busy", 32'(busy), 32'd0);
        chk("midrun_reset_outs", 32'(outs), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_hold_outs", 32'(outs), 32'd0);
        reset = 1'b1;
        run(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Moore FSM that sequences the dedicated-processor datapath through the cumulative-sum program (sum of i for i = 0..10). It drives register-file addresses, write enable, RF source-mux select, ALU opcode and output-buffer enable, and consumes the datapath's comparator flags. A start/done handshake lets a top-level wrapper or testbench launch and observe a run.

## Interface
- Parameters: none. The loop bound (10) is fixed by the datapath comparator.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  level request to run the program, sampled in IDLE
- iLe10  in  1  datapath flag: rData1 <= 10
- aBTb  in  1  datapath flag: rData1 <= rData2; reserved, ignored by this program
- RFSrcMuxSel  out  1  0 = write ALU result, 1 = write constant 1
- readAddr1  out  3  RF read port 1 address (R0 reads as 0)
- readAddr2  out  3  RF read port 2 address
- writeAddr  out  3  RF write address
- writeEn  out  1  RF write enable
- outBuf  out  1  output-register load enable (loads rData1)
- aluOP  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high only in DONE

## Operation
- Register map: R1 = i, R2 = sum, R3 = constant 1.
- All outputs are decoded combinationally from the state register only (Moore). Any field not listed below is 0: addresses 0, aluOP 000, writeEn 0, outBuf 0, RFSrcMuxSel 0.
- IDLE: all outputs 0. Go to INIT_I if start = 1, else stay in IDLE.
- INIT_I: readAddr1 = 0, readAddr2 = 0, aluOP = add, writeAddr = 1, writeEn = 1, so R1 <= 0. Go to INIT_S.
- INIT_S: same as INIT_I with writeAddr = 2, so R2 <= 0. Go to INIT_ONE.
- INIT_ONE: RFSrcMuxSel = 1, writeAddr = 3, writeEn = 1, so R3 <= 1. Go to COMP.
- COMP: readAddr1 = 1. Go to ADD_SUM if iLe10 = 1, else DONE.
- ADD_SUM: readAddr1 = 2, readAddr2 = 1, aluOP = add, writeAddr = 2, writeEn = 1, so R2 <= R2 + R1. Go to INC_I.
- INC_I: readAddr1 = 1, readAddr2 = 3, aluOP = add, writeAddr = 1, writeEn = 1, so R1 <= R1 + 1. Go to OUT.
- OUT: readAddr1 = 2, outBuf = 1. Go to COMP.
- DONE: readAddr1 = 2, done = 1. Go to IDLE when start = 0; stay while start = 1.
- start is ignored in every state except IDLE and DONE. A held start does not retrigger a run until it has been low for at least one cycle.
- Illegal state encodings go to IDLE on the next edge, with outputs as in IDLE.
- Arithmetic is 8-bit inside the datapath. The final sum, 55, does not overflow.

## Timing
- Reset asserted (reset = 0): the state goes to IDLE immediately (asynchronous). All outputs read 0 in the same cycle, including busy = 0 and done = 0.
- Reset mid-run: the run is aborted with no further writes. RF contents are left stale and are re-initialised by the next run.
- One state per clock. iLe10 is sampled at the rising edge that ends COMP.
- Edge numbering: start is sampled at edge 0.
  - INIT_I, INIT_S, INIT_ONE occupy cycles 1–3.
  - The loop runs 11 passes (i = 0..10) of 4 cycles each, cycles 4–47.
  - The final COMP (i = 11) is cycle 48.
  - done = 1 from cycle 49.
- The outPort sequence after each OUT edge is 0, 1, 3, 6, 10, 15, 21, 28, 36, 45, 55. It is stable at 55 in DONE.
- busy = 1 exactly during cycles 1–48.

## Test plan
- Reset then run: hold reset = 0 for 3 cycles and check all outputs = 0. Release, pulse start high for 1 cycle -> done rises 49 cycles after the start edge, and the datapath outPort = 55 (0x37).
- Output trace: same run -> outPort updates exactly 11 times with the values 0, 1, 3, …, 55, spaced 4 cycles apart.
- Held start: keep start = 1 through the run -> the FSM stays in DONE with done = 1. Drop start -> IDLE next cycle with done = 0. Raise start -> a new run completes with 55 again.
- Start during busy: toggle start at random while busy = 1 -> no change in the state sequence or the cycle count.
- Async reset mid-run: assert reset = 0 during ADD_SUM at loop pass 5 -> writeEn and busy drop to 0 within the same cycle. A fresh start still yields 55.
- Per-state decode: check each state's aluOP, addresses, writeEn, outBuf and RFSrcMuxSel against the Operation list (for example INC_I: readAddr1 = 1, readAddr2 = 3, writeAddr = 1, writeEn = 1, aluOP = 000).
